// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_mem_pkg;

  // Default SRAM word-address width: 512 words of 32 bits (2 KiB)
  localparam int DEFAULT_SRAM_AW = 9;

  // Load encodings of Funct3
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store encodings of Funct3
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  // Load sequencing: request in IDLE, data returns in RESP, result visible in DONE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Funct3[1:0] encodes the access size; halfwords need an even address,
  // words need a word-aligned address, bytes are always aligned.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    return ((f3[1:0] == 2'b01) && lane[0]) ||
           ((f3[1:0] == 2'b10) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/datamem_responder_load_extend.sv
// Selects the addressed byte/halfword of a 32-bit word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the byte and halfword lanes addressed by the low address bits
  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  // Extend the selected lane according to the load type
  always_comb begin
    result = word;
    case (funct3)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LW:      result = word;
      LBU:     result = {24'd0, byte_sel};
      LHU:     result = {16'd0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/datamem_responder.sv
// Data-memory responder between the core's load/store unit and a 1-cycle SRAM.
// Latency: stores complete in the request cycle; loads take 3 cycles (Stall high for 2).
// Backpressure: Stall holds the core during a load; illegal accesses pulse AccessErr without stalling.
module datamem_responder
  import riscv_mem_pkg::*;
#(
  parameter int SRAM_AW = DEFAULT_SRAM_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [2:0]         Funct3,
  input  logic [31:0]        Addr,
  input  logic [31:0]        WrData,
  output logic [31:0]        RdData,
  output logic               Stall,
  output logic               AccessErr,
  output logic               sram_en,
  output logic               sram_we,
  output logic [3:0]         sram_be,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        capture;
  logic        access_illegal;
  logic [3:0]  store_be;
  logic [31:0] ext_word;

  // Legality of the presented request: size/alignment, SRAM range, encoding, conflicting requests
  always_comb begin
    access_illegal = (MemRead && MemWrite) ||
                     (MemRead  && !(Funct3 inside {LB, LH, LW, LBU, LHU})) ||
                     (MemWrite && !(Funct3 inside {SB, SH, SW})) ||
                     misaligned(Funct3, Addr[1:0]) ||
                     ((Addr >> (SRAM_AW + 2)) != 32'd0);
  end

  // Store lane enables and lane-replicated store data
  always_comb begin
    store_be   = 4'b1111;
    sram_wdata = WrData;
    case (Funct3)
      SB: begin
        store_be   = 4'b0001 << Addr[1:0];
        sram_wdata = {4{WrData[7:0]}};
      end
      SH: begin
        store_be   = 4'b0011 << Addr[1:0];
        sram_wdata = {2{WrData[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        sram_wdata = WrData;
      end
    endcase
  end

  assign sram_addr = Addr[SRAM_AW+1:2];

  // State register; reset drops any load in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and request-cycle outputs; everything is forced quiet while reset is high
  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    AccessErr = 1'b0;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_be   = 4'b0000;
    capture   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (MemRead || MemWrite) begin
            if (access_illegal) begin
              AccessErr = 1'b1;
            end else if (MemRead) begin
              sram_en   = 1'b1;
              Stall     = 1'b1;
              capture   = 1'b1;
              state_nxt = RESP;
            end else begin
              sram_en = 1'b1;
              sram_we = 1'b1;
              sram_be = store_be;
            end
          end
        end
        RESP: begin
          Stall     = 1'b1;
          state_nxt = DONE;
        end
        DONE: begin
          // The core still presents the finished load this cycle; it is not reissued
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Remember load type and lane for extension when the SRAM word returns
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q   <= LB;
      lane_q <= 2'd0;
    end else if (capture) begin
      f3_q   <= Funct3;
      lane_q <= Addr[1:0];
    end
  end

  load_extend u_load_extend (
    .word   (sram_rdata),
    .lane   (lane_q),
    .funct3 (f3_q),
    .result (ext_word)
  );

  // Load result register, written only as a load leaves RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RdData <= 32'd0;
    end else if (state == RESP) begin
      RdData <= ext_word;
    end
  end

endmodule

// File: tb/tb_datamem_responder.sv
module tb_datamem_responder;

  localparam int AW     = 9;
  localparam int NBYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemRead, MemWrite;
  logic [2:0]    Funct3;
  logic [31:0]   Addr, WrData;
  logic [31:0]   RdData;
  logic          Stall, AccessErr;
  logic          sram_en, sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = 32'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  datamem_responder #(.SRAM_AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Funct3     (Funct3),
    .Addr       (Addr),
    .WrData     (WrData),
    .RdData     (RdData),
    .Stall      (Stall),
    .AccessErr  (AccessErr),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // SRAM harness: one-cycle read latency, byte-enabled writes, plus a backdoor preload port
  logic [31:0]   sram_mem [0:(1<<AW)-1];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [31:0]   poke_val = 32'd0;

  always @(posedge clk) begin
    if (poke_en) sram_mem[poke_addr] <= poke_val;
    else if (sram_en && sram_we)
      for (int b = 0; b < 4; b++)
        if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    if (sram_en && !sram_we) sram_rdata <= sram_mem[sram_addr];
  end

  // Reference model: byte-addressed little-endian memory and the last load result
  logic [7:0]  ref_mem [0:NBYTES-1];
  logic [31:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int acc_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] a);
    if (rd && wr) return 1'b0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
    if ((a % acc_bytes(f3)) != 0) return 1'b0;
    if (a >= 32'(NBYTES)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = acc_bytes(f3);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < acc_bytes(f3); i++) ref_mem[a + i] = wd[8*i +: 8];
  endtask

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    be = 4'd0;
    for (int i = 0; i < acc_bytes(f3); i++) be[a[1:0] + i] = 1'b1;
    return be;
  endfunction

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_addr = AW'(idx);
    poke_val  = val;
    for (int b = 0; b < 4; b++) ref_mem[idx*4 + b] = val[8*b +: 8];
  endtask

  task automatic set_in(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
  endtask

  // Full load: request cycle, RESP, DONE (request kept high throughout, as a stalled core does)
  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    @(negedge clk);
    set_in(1'b1, 1'b0, f3, a, $urandom);
    #1;
    chk({name, "_req_en"},    32'(sram_en),   32'd1);
    chk({name, "_req_we"},    32'(sram_we),   32'd0);
    chk({name, "_req_addr"},  32'(sram_addr), (a >> 2) & 32'h1FF);
    chk({name, "_req_stall"}, 32'(Stall),     32'd1);
    chk({name, "_req_err"},   32'(AccessErr), 32'd0);
    @(negedge clk); #1;
    chk({name, "_resp_stall"}, 32'(Stall),   32'd1);
    chk({name, "_resp_en"},    32'(sram_en), 32'd0);
    @(negedge clk); #1;
    chk({name, "_done_stall"}, 32'(Stall),   32'd0);
    chk({name, "_done_en"},    32'(sram_en), 32'd0);
    chk({name, "_rddata"},     RdData,       exp);
    last_rd = exp;
  endtask

  // Single-cycle access (store, illegal access or no request) checked against the model
  task automatic do_idle_op(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
    bit legal, req;
    legal = model_legal(rd, wr, f3, a);
    req   = rd || wr;
    @(negedge clk);
    set_in(rd, wr, f3, a, wd);
    #1;
    chk("rnd_err",   32'(AccessErr), 32'(req && !legal));
    chk("rnd_en",    32'(sram_en),   32'(req && legal));
    chk("rnd_we",    32'(sram_we),   32'(wr && legal));
    chk("rnd_stall", 32'(Stall),     32'd0);
    chk("rnd_rdhold", RdData,        last_rd);
    if (legal && wr) begin
      chk("rnd_be", 32'(sram_be), 32'(model_be(f3, a)));
      ref_store(f3, a, wd);
    end else begin
      chk("rnd_be_idle", 32'(sram_be), 32'd0);
    end
  endtask

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    logic        en, we;
    logic [3:0]  be;
    logic [31:0] saddr, swd;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic en, input logic we, input logic [3:0] be,
                              input logic [31:0] saddr, input logic [31:0] swd,
                              input logic err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.en = en; v.we = we; v.be = be; v.saddr = saddr; v.swd = swd; v.err = err;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  f3;
    int          k;
    bit          rd, wr;

    // Reset state, with requests presented that must not take effect
    reset = 1'b1;
    set_in(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
    last_rd = 32'd0;
    #2;
    chk("rst_stall", 32'(Stall),     32'd0);
    chk("rst_err",   32'(AccessErr), 32'd0);
    chk("rst_en",    32'(sram_en),   32'd0);
    chk("rst_we",    32'(sram_we),   32'd0);
    chk("rst_be",    32'(sram_be),   32'd0);
    chk("rst_rd",    RdData,         32'd0);
    set_in(1'b1, 1'b1, 3'd2, 32'h10, 32'd0);
    #1;
    chk("rst_err_both", 32'(AccessErr), 32'd0);
    set_in(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    // Preload SRAM and reference with random words, then known patterns
    for (int i = 0; i < (1 << AW); i++) poke(i, $urandom);
    poke(4, 32'hDEADBEEF);
    poke(0, 32'h80FF7F01);
    @(negedge clk);
    poke_en = 1'b0;
    reset   = 1'b0;

    // Directed loads
    do_load("lw_0x10",  3'd2, 32'h10, 32'hDEADBEEF);
    do_load("lb_0x3",   3'd0, 32'h3,  32'hFFFFFF80);
    do_load("lbu_0x3",  3'd4, 32'h3,  32'h00000080);
    do_load("lh_0x2",   3'd1, 32'h2,  32'hFFFF80FF);
    do_load("lhu_0x2",  3'd5, 32'h2,  32'h000080FF);
    do_load("lb_0x0",   3'd0, 32'h0,  32'h00000001);
    do_load("lw_0x0",   3'd2, 32'h0,  32'h80FF7F01);

    // Single-cycle vectors: stores, idle and illegal accesses
    tbl[0]  = mk(0, 1, 3'd0, 32'h6,     32'h000000AB, 1, 1, 4'b0100, 32'h1,   32'hABABABAB, 0);
    tbl[1]  = mk(0, 1, 3'd0, 32'h3,     32'h12345678, 1, 1, 4'b1000, 32'h0,   32'h78787878, 0);
    tbl[2]  = mk(0, 1, 3'd1, 32'h2,     32'hCAFE1234, 1, 1, 4'b1100, 32'h0,   32'h12341234, 0);
    tbl[3]  = mk(0, 1, 3'd1, 32'h104,   32'h0000BEEF, 1, 1, 4'b0011, 32'h41,  32'hBEEFBEEF, 0);
    tbl[4]  = mk(0, 1, 3'd2, 32'h7FC,   32'h01234567, 1, 1, 4'b1111, 32'h1FF, 32'h01234567, 0);
    tbl[5]  = mk(0, 0, 3'd2, 32'h20,    32'hFFFFFFFF, 0, 0, 4'b0000, 32'h0,   32'h0,        0);
    tbl[6]  = mk(1, 0, 3'd2, 32'h2,     32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        1);
    tbl[7]  = mk(0, 1, 3'd1, 32'h1,     32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        1);
    tbl[8]  = mk(1, 0, 3'd2, 32'h800,   32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        1);
    tbl[9]  = mk(1, 1, 3'd2, 32'h0,     32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        1);
    tbl[10] = mk(0, 1, 3'd4, 32'h0,     32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        1);
    tbl[11] = mk(1, 0, 3'd3, 32'h0,     32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        1);
    tbl[12] = mk(1, 0, 3'd6, 32'h0,     32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        1);
    tbl[13] = mk(0, 1, 3'd2, 32'h1000,  32'h0,        0, 0, 4'b0000, 32'h0,   32'h0,        1);
    tbl[14] = mk(1, 0, 3'd4, 32'hFFFFFFFF, 32'h0,     0, 0, 4'b0000, 32'h0,   32'h0,        1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      set_in(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd);
      #1;
      chk($sformatf("vec%0d_en", i),    32'(sram_en),   32'(tbl[i].en));
      chk($sformatf("vec%0d_we", i),    32'(sram_we),   32'(tbl[i].we));
      chk($sformatf("vec%0d_be", i),    32'(sram_be),   32'(tbl[i].be));
      chk($sformatf("vec%0d_stall", i), 32'(Stall),     32'd0);
      chk($sformatf("vec%0d_err", i),   32'(AccessErr), 32'(tbl[i].err));
      chk($sformatf("vec%0d_rd", i),    RdData,         last_rd);
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_saddr", i), 32'(sram_addr), tbl[i].saddr);
        chk($sformatf("vec%0d_swd", i),   sram_wdata,     tbl[i].swd);
        ref_store(tbl[i].f3, tbl[i].addr, tbl[i].wd);
      end
    end

    // Read back what the vector stores wrote
    do_load("rb_lw_0x0",   3'd2, 32'h0,   model_load(3'd2, 32'h0));
    do_load("rb_lw_0x4",   3'd2, 32'h4,   model_load(3'd2, 32'h4));
    do_load("rb_lhu_0x104", 3'd5, 32'h104, 32'h0000BEEF);
    do_load("rb_lw_0x7fc", 3'd2, 32'h7FC, 32'h01234567);

    // Reset during RESP aborts the load; a later load completes and memory is untouched
    @(negedge clk);
    set_in(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_stall", 32'(Stall),     32'd0);
    chk("abort_rd",    RdData,         32'd0);
    chk("abort_en",    32'(sram_en),   32'd0);
    chk("abort_err",   32'(AccessErr), 32'd0);
    set_in(1'b0, 1'b1, 3'd2, 32'h10, 32'hFFFFFFFF);
    #1;
    chk("abort_no_write", 32'(sram_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    last_rd = 32'd0;
    do_load("post_abort_lw", 3'd2, 32'h10, 32'hDEADBEEF);

    // Randomized mix against the reference model
    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 19);
      rd = (k < 10) || (k == 18);
      wr = (k >= 10 && k < 18) || (k == 18);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (rd) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end else f3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 99) < 85) begin
        a = 32'($urandom_range(0, NBYTES - 1));
        if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_bytes(f3) - 1);
      end else begin
        a = $urandom | 32'h00000800;
      end
      wd = $urandom;
      if (rd && !wr && model_legal(1'b1, 1'b0, f3, a))
        do_load("rnd_load", f3, a, model_load(f3, a));
      else
        do_idle_op(rd, wr, f3, a, wd);
    end

    @(negedge clk);
    set_in(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
